traffic_fsm_single_ctrl: RTL and testbench
==========================================

# traffic_fsm_single_ctrl

Single-direction traffic-light controller. It cycles through RED → GREEN → YELLOW → RED, with a programmable duration for each phase. It also exposes the remaining time in the current phase for a countdown display. The block is a leaf next to the board-level LED/7-segment drivers; an optional internal prescaler derives the per-second tick from the system clock.

## Interface
Parameters:
- RED_TIME, default 30: RED phase length in ticks, legal range 1..63.
- GREEN_TIME, default 25: GREEN phase length in ticks, legal range 1..63.
- YELLOW_TIME, default 5: YELLOW phase length in ticks, legal range 1..63.
- CLK_DIV, default 1: clock cycles per tick, ≥1. Use 1 for simulation; use the clock frequency in Hz for 1 Hz on hardware.

Ports:
- clk, input, 1: sole clock. All state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- led, output, 2: current light. 2'b00 = RED, 2'b01 = GREEN, 2'b10 = YELLOW. 2'b11 is never driven.
- timer_value, output, 6: ticks remaining in the current phase, unsigned.

## Operation
- FSM states RED, GREEN, YELLOW. `led` is a registered direct encoding of the state.
- Prescaler `div_cnt` counts 0..CLK_DIV-1. `tick` asserts in the cycle where div_cnt == CLK_DIV-1, and div_cnt then wraps to 0. With CLK_DIV = 1, tick is high every cycle.
- On each tick:
  - If timer_value > 1: decrement timer_value.
  - If timer_value == 1: advance the state and load the next phase's duration into timer_value.
- Transitions: RED → GREEN loads GREEN_TIME; GREEN → YELLOW loads YELLOW_TIME; YELLOW → RED loads RED_TIME. There are no other transitions.
- timer_value therefore shows DURATION, DURATION-1, …, 1 for each phase. It never shows 0 in normal operation.
- Illegal state encoding: recover to RED with timer_value = RED_TIME on the next clock edge, independent of tick.
- Parameters outside their legal range are a configuration error, flagged by an elaboration-time check. The RTL need not handle them.

## Timing
- Reset values when rst is high at a clock edge: state RED, led = 2'b00, timer_value = RED_TIME, div_cnt = 0. Reset overrides tick.
- Reset applied mid-phase restarts the sequence from RED / RED_TIME on the next edge.
- Outputs are registered. They change only on the rising edge after a tick, with no combinational path from rst to any output.
- With CLK_DIV = 1, the first post-reset edge with rst low is tick 1.
  - RED holds for RED_TIME edges.
  - GREEN holds for GREEN_TIME edges.
  - YELLOW holds for YELLOW_TIME edges.
  - Full period = RED_TIME + GREEN_TIME + YELLOW_TIME edges (60 cycles with defaults).
- A duration of 1 gives a one-tick phase: timer_value = 1 for that tick, then the next transition.
- With CLK_DIV = N, every timer/state change is spaced N cycles apart.

## Structure
- Shared package `traffic_pkg` holds:
  - State/LED encoding constants LED_RED, LED_GREEN, LED_YELLOW.
  - The 6-bit timer width constant TIMER_W = 6.
- One natural sub-module, `tick_gen`: parameterized by CLK_DIV, synchronous reset, outputs a one-cycle `tick`.
- The top level holds the FSM and the countdown register.

## Test plan
- Reset: hold rst high for 2 cycles → led = 00, timer_value = 30. Release → timer_value reads 29 after the first edge.
- Full cycle, defaults, CLK_DIV = 1:
  - led = 00 for 30 cycles, then 01 with timer_value = 25.
  - After 25 cycles: led = 10 with timer_value = 5.
  - After 5 cycles: led = 00 with timer_value = 30.
  - 100 cycles covers one full period plus a second RED.
- Countdown monotonicity: across every phase timer_value decrements by exactly 1 per tick, never reads 0, and never reads above the phase duration.
- Mid-phase reset: assert rst at GREEN with timer_value = 12 → next edge gives led = 00, timer_value = 30.
- Edge durations: RED_TIME = GREEN_TIME = YELLOW_TIME = 1 → led steps 00 → 01 → 10 → 00 on consecutive edges, with timer_value constantly 1.
- Prescaler: CLK_DIV = 4 → timer_value and led change only every 4th edge. RED lasts 120 cycles with defaults.

Source files
------------

// File: rtl/traffic_fsm_single_ctrl_pkg.sv
// Shared encodings and widths for the single-direction traffic-light controller.
// The state encoding is the LED encoding, so led can be driven straight from the state register.
package traffic_pkg;

  localparam int TIMER_W = 6;

  localparam logic [1:0] LED_RED    = 2'b00;
  localparam logic [1:0] LED_GREEN  = 2'b01;
  localparam logic [1:0] LED_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_RED    = LED_RED,
    ST_GREEN  = LED_GREEN,
    ST_YELLOW = LED_YELLOW
  } state_t;

  function automatic state_t next_phase(state_t cur);
    case (cur)
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_YELLOW;
      default:  return ST_RED;
    endcase
  endfunction

  function automatic bit duration_ok(int t);
    return (t >= 1) && (t <= 63);
  endfunction

endpackage

// File: rtl/traffic_fsm_single_ctrl_if.sv
// Display-side bundle: the current light and the countdown of the current phase.
interface traffic_fsm_single_ctrl_if;
  import traffic_pkg::*;

  logic [1:0]         led;
  logic [TIMER_W-1:0] timer_value;

  modport master (output led, output timer_value);
  modport slave  (input  led, input  timer_value);
endinterface

// File: rtl/traffic_fsm_single_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks. With CLK_DIV = 1 the tick is held high.
module tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;

  assign tick_o = (div_cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick_o) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_fsm_single_ctrl.sv
// Traffic-light sequencer RED -> GREEN -> YELLOW -> RED with a per-phase countdown.
// The countdown shows DURATION..1 and the phase advances on the tick that finds it at 1.
module traffic_fsm_single_ctrl
  import traffic_pkg::*;
#(
  parameter int RED_TIME    = 30,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int CLK_DIV     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_fsm_single_ctrl_if.master  disp
);

  if (!duration_ok(RED_TIME)) begin : g_bad_red
    $error("RED_TIME out of range 1..63");
  end
  if (!duration_ok(GREEN_TIME)) begin : g_bad_green
    $error("GREEN_TIME out of range 1..63");
  end
  if (!duration_ok(YELLOW_TIME)) begin : g_bad_yellow
    $error("YELLOW_TIME out of range 1..63");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end

  localparam logic [TIMER_W-1:0] RED_T    = TIMER_W'(RED_TIME);
  localparam logic [TIMER_W-1:0] GREEN_T  = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] YELLOW_T = TIMER_W'(YELLOW_TIME);

  function automatic logic [TIMER_W-1:0] phase_len(state_t s);
    case (s)
      ST_GREEN:  return GREEN_T;
      ST_YELLOW: return YELLOW_T;
      default:   return RED_T;
    endcase
  endfunction

  state_t             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RED;
      timer_q <= RED_T;
    end else begin
      case (state_q)
        ST_RED, ST_GREEN, ST_YELLOW: begin
          if (tick) begin
            if (timer_q > TIMER_W'(1)) begin
              timer_q <= timer_q - 1'b1;
            end else begin
              state_q <= next_phase(state_q);
              timer_q <= phase_len(next_phase(state_q));
            end
          end
        end
        // Corrupted encoding recovers immediately, without waiting for a tick.
        default: begin
          state_q <= ST_RED;
          timer_q <= RED_T;
        end
      endcase
    end
  end

  assign disp.led         = state_q;
  assign disp.timer_value = timer_q;

endmodule

// File: tb/tb_traffic_fsm_single_ctrl.sv
// Bench: four controller configurations share clock and reset and are compared every cycle
// against a model that derives light and countdown from elapsed ticks since reset.
module tb_traffic_fsm_single_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_fsm_single_ctrl_if bus0 ();
  traffic_fsm_single_ctrl_if bus1 ();
  traffic_fsm_single_ctrl_if bus2 ();
  traffic_fsm_single_ctrl_if bus3 ();

  traffic_fsm_single_ctrl u_dut_def (.clk(clk), .rst(rst), .disp(bus0));
  traffic_fsm_single_ctrl #(.RED_TIME(1), .GREEN_TIME(1), .YELLOW_TIME(1), .CLK_DIV(1))
    u_dut_one (.clk(clk), .rst(rst), .disp(bus1));
  traffic_fsm_single_ctrl #(.CLK_DIV(4)) u_dut_div4 (.clk(clk), .rst(rst), .disp(bus2));
  traffic_fsm_single_ctrl #(.RED_TIME(7), .GREEN_TIME(3), .YELLOW_TIME(2), .CLK_DIV(3))
    u_dut_mix (.clk(clk), .rst(rst), .disp(bus3));

  int n_tests = 0;
  int n_fail  = 0;
  int n_edges = 0;
  bit armed   = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Light and countdown as a function of edges since reset: position within the period.
  function automatic void model(input int r, input int g, input int y, input int div,
                                input int n, output int led, output int tmr);
    int t;
    int p;
    t = n / div;
    p = t % (r + g + y);
    if (p < r) begin
      led = 0; tmr = r - p;
    end else if (p < r + g) begin
      led = 1; tmr = r + g - p;
    end else begin
      led = 2; tmr = r + g + y - p;
    end
  endfunction

  task automatic check_dut(input string nm, input int led, input int tmr,
                           input int r, input int g, input int y, input int div);
    int el;
    int et;
    model(r, g, y, div, n_edges, el, et);
    chk({nm, "_led"}, led, el);
    chk({nm, "_timer"}, tmr, et);
    chk({nm, "_nonzero"}, int'(tmr != 0), 1);
  endtask

  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check_dut("def",  int'(bus0.led), int'(bus0.timer_value), 30, 25, 5, 1);
      check_dut("one",  int'(bus1.led), int'(bus1.timer_value), 1, 1, 1, 1);
      check_dut("div4", int'(bus2.led), int'(bus2.timer_value), 30, 25, 5, 4);
      check_dut("mix",  int'(bus3.led), int'(bus3.timer_value), 7, 3, 2, 3);
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    chk("rst_led", int'(bus0.led), 0);
    chk("rst_timer", int'(bus0.timer_value), 30);
    chk("rst_timer_one", int'(bus1.timer_value), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tick_timer", int'(bus0.timer_value), 29);
    chk("first_tick_div4", int'(bus2.timer_value), 30);
    chk("one_step_green", int'(bus1.led), 1);

    repeat (100) @(negedge clk);

    // Reset in the middle of GREEN must restart RED from its full duration.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = (bus0.led == 2'b01) && (bus0.timer_value == 6'd12);
    end
    chk("wait_green_12", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_led", int'(bus0.led), 0);
    chk("midrst_timer", int'(bus0.timer_value), 30);
    rst = 1'b0;

    // Full RED phase with CLK_DIV = 4 lasts 120 cycles.
    repeat (119) @(negedge clk);
    chk("div4_red_end_led", int'(bus2.led), 0);
    chk("div4_red_end_timer", int'(bus2.timer_value), 1);
    @(negedge clk);
    chk("div4_green_led", int'(bus2.led), 1);
    chk("div4_green_timer", int'(bus2.timer_value), 25);

    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
